// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // Clocks per UART bit, truncated.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: line level is computed one cycle ahead so tx is a flop.
  always_comb begin
    // NOTE: every variable gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          done    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between byte producers,
// holding the grant across multi-byte packets.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 115200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       usb_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);

  localparam int ID_W         = $clog2(NUM_REQ);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [NUM_REQ-1:0] ready_q;
  logic               start_q;
  logic [7:0]         data_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    ptr_q;
  logic               locked_q;

  logic               ser_busy;
  logic               ser_done;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    idx;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_found;
  logic               can_accept;
  logic               accept;

  // Requester selection: first eligible one searching upward from ptr.
  always_comb begin
    grant_mask          = '0;
    grant_mask[grant_q] = 1'b1;
    eligible            = locked_q ? (req_valid & grant_mask) : req_valid;
    idx                 = '0;
    pick_idx            = '0;
    pick_found          = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
    // The line is free when idle and no start is in flight, or on the
    // last stop-bit cycle so the next accept lands on the single idle cycle.
    can_accept = (!ser_busy && !start_q) || ser_done;
    accept     = can_accept && pick_found;
  end

  // Grant, lock and rotation pointer; req_ready is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      ready_q <= '0;
      start_q <= accept;
      if (accept) begin
        ready_q[pick_idx] <= 1'b1;
        data_q            <= req_data[8*pick_idx +: 8];
        grant_q           <= pick_idx;
        if (req_last[pick_idx]) begin
          locked_q <= 1'b0;
          ptr_q    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else begin
          locked_q <= 1'b1;
        end
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(start_q),
    .data (data_q),
    .tx   (usb_tx),
    .busy (ser_busy),
    .done (ser_done)
  );

  assign req_ready = ready_q;
  assign busy      = ser_busy;
  assign grant_id  = grant_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT = 8, four requesters.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 8;
  localparam int FRAME   = FRAME_BITS * CPB;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         usb_tx;
  logic         busy;
  logic [1:0]   grant_id;
  logic         locked;

  int checks;
  int errors;
  int cyc;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLK_HZ (8),
    .BAUD   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .usb_tx   (usb_tx),
    .busy     (busy),
    .grant_id (grant_id),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for any req_ready pulse; seen stays 0 if the budget expires.
  task automatic wait_accept(input int budget, output logic [3:0] seen, output int at);
    seen = '0;
    at   = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req_ready != '0) begin
        seen = req_ready;
        at   = cyc;
        break;
      end
    end
  endtask

  function automatic logic [79:0] frame_bits(input logic [7:0] b);
    logic [79:0] r;
    for (int i = 0; i < FRAME; i++) begin
      if (i < CPB)             r[i] = 1'b0;
      else if (i < 9 * CPB)    r[i] = b[(i - CPB) / CPB];
      else                     r[i] = 1'b1;
    end
    return r;
  endfunction

  // Captures the FRAME cycles following an accept and compares the line.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [79:0] tx_seen;
    logic [79:0] busy_seen;
    logic [3:0]  ready_or;
    ready_or = '0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      tx_seen[i]   = usb_tx;
      busy_seen[i] = busy;
      ready_or     = ready_or | req_ready;
    end
    chk({tag, "_tx"}, tx_seen, frame_bits(b));
    chk({tag, "_busy"}, busy_seen, {80{1'b1}});
    chk({tag, "_ready_mid"}, ready_or, 4'b0000);
  endtask

  logic [3:0] seen;
  int         at;
  int         prev_at;
  logic [3:0] ready_or;
  logic       tx_and;
  logic       busy_or;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_tx", usb_tx, 1'b1);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ptr", dut.ptr_q, 2'd0);
    rst = 1'b0;

    // Single byte from requester 2.
    req_data[23:16] = 8'hA5;
    req_last        = 4'b0100;
    req_valid       = 4'b0100;
    wait_accept(20, seen, at);
    chk("single_ready", seen, 4'b0100);
    chk("single_grant", grant_id, 2'd2);
    req_valid = '0;
    check_frame("single", 8'hA5);
    tick();
    chk("single_idle_tx", usb_tx, 1'b1);
    chk("single_idle_busy", busy, 1'b0);
    chk("single_ptr", dut.ptr_q, 2'd3);

    // Contention: 0, 1, 3 held valid, single-byte packets, from ptr 0.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_data  = 32'h33_22_11_00;
    req_last  = 4'b1111;
    req_valid = 4'b1011;
    wait_accept(20, seen, at);
    chk("cont_g0", seen, 4'b0001);
    prev_at = at;
    wait_accept(100, seen, at);
    chk("cont_g1", seen, 4'b0010);
    chk("cont_gap1", at - prev_at, FRAME + 1);
    prev_at = at;
    wait_accept(100, seen, at);
    chk("cont_g2", seen, 4'b1000);
    chk("cont_gap2", at - prev_at, FRAME + 1);
    prev_at = at;
    wait_accept(100, seen, at);
    chk("cont_g3", seen, 4'b0001);
    chk("cont_gap3", at - prev_at, FRAME + 1);

    // Lock: requester 1 sends three bytes while 0 stays valid (ptr is 1).
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    wait_accept(100, seen, at);
    chk("lock_b1", seen, 4'b0010);
    chk("lock_b1_locked", locked, 1'b1);
    wait_accept(100, seen, at);
    chk("lock_b2", seen, 4'b0010);
    chk("lock_b2_locked", locked, 1'b1);
    req_last[1] = 1'b1;
    wait_accept(100, seen, at);
    chk("lock_b3", seen, 4'b0010);
    chk("lock_b3_locked", locked, 1'b0);
    req_valid[1] = 1'b0;
    wait_accept(100, seen, at);
    chk("lock_after", seen, 4'b0001);

    // Locked stall: requester 1 opens a packet then goes quiet; 2 waits.
    req_valid       = 4'b0110;
    req_last        = 4'b0000;
    req_data[23:16] = 8'h42;
    wait_accept(100, seen, at);
    chk("stall_open", seen, 4'b0010);
    chk("stall_open_locked", locked, 1'b1);
    req_valid[1] = 1'b0;
    ready_or = '0;
    for (int i = 0; i < 200; i++) begin
      tick();
      ready_or = ready_or | req_ready;
    end
    chk("stall_no_grant", ready_or, 4'b0000);
    chk("stall_locked", locked, 1'b1);
    chk("stall_busy", busy, 1'b0);
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b1;
    wait_accept(20, seen, at);
    chk("stall_close", seen, 4'b0010);
    chk("stall_close_locked", locked, 1'b0);
    req_valid[1] = 1'b0;
    prev_at = at;
    wait_accept(100, seen, at);
    chk("stall_then_req2", seen, 4'b0100);
    chk("stall_gap", at - prev_at, FRAME + 1);
    chk("stall_req2_locked", locked, 1'b1);
    req_valid = '0;

    // Reset mid-frame during data bit 3 of 0x42 (bit 3 is 0).
    for (int i = 0; i < 36; i++) tick();
    chk("mid_tx_bit3", usb_tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", usb_tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_ptr", dut.ptr_q, 2'd0);
    chk("mid_rst_grant", grant_id, 2'd0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    rst             = 1'b0;
    req_data[31:24] = 8'h5A;
    req_last        = 4'b1000;
    req_valid       = 4'b1000;
    wait_accept(5, seen, at);
    chk("post_rst_ready", seen, 4'b1000);
    chk("post_rst_grant", grant_id, 2'd3);
    req_valid = '0;
    check_frame("post_rst", 8'h5A);
    tick();
    chk("post_rst_ptr_wrap", dut.ptr_q, 2'd0);

    // No requests for 1000 cycles.
    ready_or = '0;
    tx_and   = 1'b1;
    busy_or  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      ready_or = ready_or | req_ready;
      tx_and   = tx_and & usb_tx;
      busy_or  = busy_or | busy;
    end
    chk("quiet_ready", ready_or, 4'b0000);
    chk("quiet_tx", tx_and, 1'b1);
    chk("quiet_busy", busy_or, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
